vec_seq_control_unit: RTL and testbench

VEC_SEQ_CONTROL_UNIT -- requirements
Module: vec_seq_control_unit

---
 rtl/vec_seq_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_vec_seq_control_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_seq_control_unit.sv
// Vector-aware control unit: decodes an instruction into registered micro-op controls
// and replays vector instructions as VLEN/LANES beats. Define VEC_SEQ_MASK_EN for per-lane masking.
module vec_seq_control_unit #(
   parameter int VLEN  = 8,
   parameter int LANES = 2,
   localparam int BEATS = VLEN / LANES,
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       op,
   input  logic [2:0]       func3,
   input  logic [10:0]      func11,
`ifdef VEC_SEQ_MASK_EN
   input  logic [VLEN-1:0]  vmask,
`endif
   input  logic             stall_in,
   output logic             uop_valid,
   output logic             reg_write,
   output logic             mem_write,
   output logic             mem_read,
   output logic             jump,
   output logic             jump_cond,
   output logic             alu_src_op1,
   output logic             alu_src_op2,
   output logic             pc_target_src,
   output logic             vector_op,
   output logic [2:0]       jump_cond_type,
   output logic [3:0]       alu_control,
   output logic [3:0]       imm_src,
   output logic [1:0]       result_src,
   output logic [BW-1:0]    beat_idx,
   output logic [LANES-1:0] lane_mask,
   output logic             last_beat,
   output logic             illegal_op
);

   localparam logic [BW-1:0] IDX_LAST = BW'(BEATS - 1);
   localparam logic [BW-1:0] IDX_PEN  = BW'((BEATS > 1) ? (BEATS - 2) : 0);

   typedef enum logic {S_IDLE, S_VEC} state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       jump;
      logic       jump_cond;
      logic       alu_src_op1;
      logic       alu_src_op2;
      logic       pc_target_src;
      logic       vector_op;
      logic [2:0] jump_cond_type;
      logic [3:0] alu_control;
      logic [3:0] imm_src;
      logic [1:0] result_src;
      logic       illegal_op;
   } dec_t;

   function automatic logic [LANES-1:0] lane_slice(input logic [VLEN-1:0] m, input logic [BW-1:0] k);
      return m[int'(k) * LANES +: LANES];
   endfunction

   state_t           r_state, w_state_nxt;
   dec_t             r_dec, w_dec;
   logic             r_uop_valid;
   logic [BW-1:0]    r_beat_idx;
   logic [LANES-1:0] r_lane_mask;
   logic             r_last_beat;
   logic [VLEN-1:0]  r_vmask;
   logic [VLEN-1:0]  w_vmask;
   logic [BW-1:0]    w_idx_nxt;
   logic             w_legal, w_accept, w_retire, w_adv;
   logic             w_unused_func11;

`ifdef VEC_SEQ_MASK_EN
   assign w_vmask = vmask;
`else
   assign w_vmask = {VLEN{1'b1}};
`endif

   assign w_unused_func11 = ^func11[10:1];

   always_comb begin
      w_dec                = '0;
      w_legal              = ~((op == 3'b100) | (op == 3'b111));
      w_dec.illegal_op     = ~w_legal;
      w_dec.reg_write      = (op[1:0] != 2'b10) & w_legal;
      w_dec.mem_write      = (op == 3'b010);
      w_dec.mem_read       = (op == 3'b101) & ((func3 == 3'b000) | (func3 == 3'b100));
      w_dec.jump_cond      = (op == 3'b110);
      w_dec.jump_cond_type = func3;
      w_dec.jump           = ((op == 3'b011) | (op == 3'b101)) & (func3 == 3'b010);
      w_dec.alu_src_op1    = (op != 3'b011);
      w_dec.alu_src_op2    = (op != 3'b000) & (op != 3'b110);
      w_dec.pc_target_src  = (op == 3'b101);
      w_dec.vector_op      = ((op == 3'b010) | (op == 3'b101)) & (func3 == 3'b100);
      case (op)
         3'b000:  w_dec.alu_control = {func11[0], func3};
         3'b001:  w_dec.alu_control = {1'b0, func3};
         3'b110:  w_dec.alu_control = 4'b0001;
         default: w_dec.alu_control = 4'b0000;
      endcase
      case (op)
         3'b001:  w_dec.imm_src = ((func3 == 3'b101) | (func3 == 3'b110)) ? 4'b0001 : 4'b0000;
         3'b010:  w_dec.imm_src = 4'b0100;
         3'b011:  w_dec.imm_src = (func3 == 3'b001) ? 4'b1110 : 4'b1100;
         3'b110:  w_dec.imm_src = 4'b1000;
         default: w_dec.imm_src = 4'b0000;
      endcase
      if ((op == 3'b011) && (func3 == 3'b010))
         w_dec.result_src = 2'b10;
      else if (w_dec.mem_read)
         w_dec.result_src = 2'b01;
   end

   // A skipped (empty-mask) beat advances on its own; a live beat only on retire.
   assign instr_ready = (~r_uop_valid | ~stall_in) & ((r_state == S_IDLE) | r_last_beat);
   assign w_accept    = instr_valid & instr_ready;
   assign w_retire    = r_uop_valid & ~stall_in;
   assign w_adv       = (r_state == S_VEC) & (~r_uop_valid | ~stall_in);
   assign w_idx_nxt   = r_beat_idx + BW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_dec.vector_op && (BEATS > 1)) w_state_nxt = S_VEC;
         S_VEC:   if (w_adv && (r_beat_idx == IDX_PEN)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dec       <= '0;
         r_uop_valid <= 1'b0;
         r_beat_idx  <= '0;
         r_lane_mask <= '0;
         r_last_beat <= 1'b0;
         r_vmask     <= '0;
      end else if (w_accept) begin
         r_dec      <= w_dec;
         r_beat_idx <= '0;
         r_vmask    <= w_vmask;
         if (w_dec.vector_op) begin
            r_lane_mask <= lane_slice(w_vmask, '0);
            r_uop_valid <= |lane_slice(w_vmask, '0);
            r_last_beat <= (BEATS == 1);
         end else begin
            r_lane_mask <= '1;
            r_uop_valid <= 1'b1;
            r_last_beat <= 1'b1;
         end
      end else if (w_adv) begin
         r_beat_idx  <= w_idx_nxt;
         r_lane_mask <= lane_slice(r_vmask, w_idx_nxt);
         r_uop_valid <= |lane_slice(r_vmask, w_idx_nxt);
         r_last_beat <= (w_idx_nxt == IDX_LAST);
      end else if (w_retire) begin
         r_uop_valid <= 1'b0;
      end
   end

   assign uop_valid      = r_uop_valid;
   assign reg_write      = r_dec.reg_write;
   assign mem_write      = r_dec.mem_write;
   assign mem_read       = r_dec.mem_read;
   assign jump           = r_dec.jump;
   assign jump_cond      = r_dec.jump_cond;
   assign alu_src_op1    = r_dec.alu_src_op1;
   assign alu_src_op2    = r_dec.alu_src_op2;
   assign pc_target_src  = r_dec.pc_target_src;
   assign vector_op      = r_dec.vector_op;
   assign jump_cond_type = r_dec.jump_cond_type;
   assign alu_control    = r_dec.alu_control;
   assign imm_src        = r_dec.imm_src;
   assign result_src     = r_dec.result_src;
   assign illegal_op     = r_dec.illegal_op;
   assign beat_idx       = r_beat_idx;
   assign lane_mask      = r_lane_mask;
   assign last_beat      = r_last_beat;

endmodule

// File: tb/tb_vec_seq_control_unit.sv
// Scoreboard bench for vec_seq_control_unit (VLEN=8, LANES=2); expected micro-ops are
// queued at acceptance and compared on retire.
module tb_vec_seq_control_unit;

   localparam int VLEN  = 8;
   localparam int LANES = 2;
   localparam int BEATS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, instr_ready;
   logic [2:0]  op, func3;
   logic [10:0] func11;
   logic [7:0]  vmask;
   logic        stall_in, uop_valid;
   logic        reg_write, mem_write, mem_read, jump, jump_cond;
   logic        alu_src_op1, alu_src_op2, pc_target_src, vector_op;
   logic [2:0]  jump_cond_type;
   logic [3:0]  alu_control, imm_src;
   logic [1:0]  result_src;
   logic [1:0]  beat_idx;
   logic [1:0]  lane_mask;
   logic        last_beat, illegal_op;

   vec_seq_control_unit #(.VLEN(VLEN), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op(op), .func3(func3), .func11(func11),
`ifdef VEC_SEQ_MASK_EN
      .vmask(vmask),
`endif
      .stall_in(stall_in), .uop_valid(uop_valid),
      .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read), .jump(jump),
      .jump_cond(jump_cond), .alu_src_op1(alu_src_op1), .alu_src_op2(alu_src_op2),
      .pc_target_src(pc_target_src), .vector_op(vector_op), .jump_cond_type(jump_cond_type),
      .alu_control(alu_control), .imm_src(imm_src), .result_src(result_src),
      .beat_idx(beat_idx), .lane_mask(lane_mask), .last_beat(last_beat), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [22:0] dec;
      logic [1:0]  idx;
      logic [1:0]  lm;
      logic        last;
   } uop_t;

   uop_t        sbq[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          stall_hold = 0;
   logic        stall_rand = 1'b0;
   logic        accepted;
   logic        prev_stalled = 1'b0;
   logic [22:0] prev_dec;
   logic [4:0]  prev_beat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [22:0] dut_dec();
      return {reg_write, mem_write, mem_read, jump, jump_cond, alu_src_op1, alu_src_op2,
              pc_target_src, vector_op, jump_cond_type, alu_control, imm_src, result_src, illegal_op};
   endfunction

   // Reference decode written op by op from the instruction table.
   function automatic logic [22:0] model(input logic [2:0] o, input logic [2:0] f3, input logic f11b0);
      logic       rw = 0, mw = 0, mr = 0, j = 0, jc = 0, s1 = 1, s2 = 1, pts = 0, vo = 0, ill = 0;
      logic [3:0] ac = 0, is = 0;
      logic [1:0] rs = 0;
      case (o)
         3'd0: begin rw = 1; s2 = 0; ac = {f11b0, f3}; end
         3'd1: begin rw = 1; ac = {1'b0, f3}; if (f3 == 3'd5 || f3 == 3'd6) is = 4'd1; end
         3'd2: begin mw = 1; is = 4'd4; vo = (f3 == 3'd4); end
         3'd3: begin rw = 1; s1 = 0; j = (f3 == 3'd2); is = (f3 == 3'd1) ? 4'd14 : 4'd12;
                     rs = (f3 == 3'd2) ? 2'd2 : 2'd0; end
         3'd5: begin rw = 1; pts = 1; j = (f3 == 3'd2); vo = (f3 == 3'd4);
                     mr = (f3 == 3'd0 || f3 == 3'd4); rs = mr ? 2'd1 : 2'd0; end
         3'd6: begin jc = 1; s2 = 0; ac = 4'd1; is = 4'd8; end
         default: ill = 1;
      endcase
      return {rw, mw, mr, j, jc, s1, s2, pts, vo, f3, ac, is, rs, ill};
   endfunction

   function automatic void push_expect();
      logic [22:0] d;
      logic [1:0]  lm;
      d = model(op, func3, func11[0]);
      if ((op == 3'd2 || op == 3'd5) && func3 == 3'd4) begin
         for (int k = 0; k < BEATS; k++) begin
`ifdef VEC_SEQ_MASK_EN
            lm = vmask[k*LANES +: LANES];
`else
            lm = 2'b11;
`endif
            if (lm != 2'b00) sbq.push_back('{d, 2'(k), lm, (k == BEATS - 1)});
         end
      end else begin
         sbq.push_back('{d, 2'd0, 2'b11, 1'b1});
      end
   endfunction

   // Entered at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
   task automatic cycle();
      uop_t e;
      #1;
      if (prev_stalled) begin
         chk("hold_valid", 32'(uop_valid), 32'(1));
         chk("hold_dec", 32'(dut_dec()), 32'(prev_dec));
         chk("hold_beat", 32'({beat_idx, lane_mask, last_beat}), 32'(prev_beat));
      end
      prev_stalled = uop_valid && stall_in;
      prev_dec     = dut_dec();
      prev_beat    = {beat_idx, lane_mask, last_beat};
      if (uop_valid && !stall_in) begin
         chk("sb_nonempty_on_uop", 32'(sbq.size() > 0), 32'(1));
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("uop_dec", 32'(dut_dec()), 32'(e.dec));
            chk("uop_beat_idx", 32'(beat_idx), 32'(e.idx));
            chk("uop_lane_mask", 32'(lane_mask), 32'(e.lm));
            chk("uop_last_beat", 32'(last_beat), 32'(e.last));
            chk("ready_on_retire", 32'(instr_ready), 32'(e.last));
         end
      end
      if (instr_valid && instr_ready) begin
         accepted = 1'b1;
         push_expect();
      end
      @(posedge clk);
      #1;
      if (stall_hold > 0) begin
         stall_in = 1'b1;
         stall_hold--;
      end else begin
         stall_in = stall_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [2:0] f3, input logic [10:0] f11,
                        input logic [7:0] vm);
      op = o; func3 = f3; func11 = f11; vmask = vm;
      instr_valid = 1'b1;
      accepted    = 1'b0;
      for (int i = 0; i < 64 && !accepted; i++) cycle();
      instr_valid = 1'b0;
      chk("accept_in_budget", 32'(accepted), 32'(1));
   endtask

   task automatic drain();
      int i;
      instr_valid = 1'b0;
      for (i = 0; i < 200; i++) begin
         if (sbq.size() == 0 && !uop_valid) break;
         cycle();
      end
      chk("drain_in_budget", 32'(i < 200), 32'(1));
      chk("sb_empty_after_drain", 32'(sbq.size()), 32'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; op = '0; func3 = '0; func11 = '0; vmask = '0; stall_in = 1'b0;
      #2;
      chk("rst_uop_valid", 32'(uop_valid), 32'(0));
      chk("rst_dec", 32'(dut_dec()), 32'(0));
      chk("rst_beat", 32'({beat_idx, lane_mask, last_beat}), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("ready_after_por", 32'(instr_ready), 32'(1));

      // ALU register op with func11[0] set
      issue(3'd0, 3'd3, 11'h001, 8'hFF);
      #1;
      chk("alu_uop_valid", 32'(uop_valid), 32'(1));
      chk("alu_control", 32'(alu_control), 32'(4'b1011));
      chk("alu_reg_write", 32'(reg_write), 32'(1));
      chk("alu_result_src", 32'(result_src), 32'(0));
      drain();

      // Vector load, four beats without stall
      issue(3'd5, 3'd4, 11'h0, 8'hFF);
      #1;
      chk("vld_beat0_idx", 32'(beat_idx), 32'(0));
      chk("vld_beat0_ready", 32'(instr_ready), 32'(0));
      chk("vld_mem_read", 32'(mem_read), 32'(1));
      chk("vld_vector_op", 32'(vector_op), 32'(1));
      drain();

      // Vector store stalled for three cycles on beat 1
      issue(3'd2, 3'd4, 11'h0, 8'hFF);
      stall_hold = 3;
      cycle();
      chk("stall_beat_idx", 32'(beat_idx), 32'(1));
      chk("stall_ready", 32'(instr_ready), 32'(0));
      drain();

      // Illegal opcode
      issue(3'd7, 3'd0, 11'h0, 8'hFF);
      #1;
      chk("ill_flag", 32'(illegal_op), 32'(1));
      chk("ill_wr_bits", 32'({reg_write, mem_write, jump}), 32'(0));
      drain();

      // Reset in the middle of a vector sequence
      issue(3'd5, 3'd4, 11'h0, 8'hFF);
      cycle();
      cycle();
      chk("pre_rst_beat_idx", 32'(beat_idx), 32'(2));
      rst = 1'b1;
      #1;
      chk("rst_mid_uop_valid", 32'(uop_valid), 32'(0));
      chk("rst_mid_beat_idx", 32'(beat_idx), 32'(0));
      sbq.delete();
      prev_stalled = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(instr_ready), 32'(1));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         chk("no_beat_after_rst", 32'(uop_valid), 32'(0));
      end

`ifdef VEC_SEQ_MASK_EN
      // Only lanes of beat 2 enabled
      issue(3'd5, 3'd4, 11'h0, 8'h30);
      #1;
      chk("mask_skip_beat0", 32'(uop_valid), 32'(0));
      drain();
      chk("mask_seq_ended", 32'(instr_ready), 32'(1));
`endif

      // Random traffic with random stalls, biased towards vector instructions
      stall_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         logic [2:0] o, f3;
         o  = 3'($urandom_range(0, 7));
         f3 = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
         issue(o, f3, 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)));
      end
      drain();
      stall_rand = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
